// File: rtl/vga_pkg.sv
// 640x480@60 raster timing constants and a line/frame total helper shared by
// the VGA timing generator files.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_CW       = 12;

  // Period of one axis in its own units (pixels per line or lines per frame).
  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational sync/active
// decode of the current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          restart,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          active
);

  localparam int unsigned TOT        = vga_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;

  logic [31:0] count_u;

  assign count_u = 32'(count);
  assign wrap    = advance && (count_u == (TOT - 1));
  assign active  = (count_u < ACTIVE);
  assign sync    = ((count_u >= SYNC_START) && (count_u < SYNC_END)) ? POL : ~POL;

  // Restart wins over a simultaneous advance or wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (advance) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised single-clock VGA raster timing generator driven by a pixel-enable.
// Optional frame counter on o_frame_cnt when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CW         = VGA_CW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pix_en,
  input  logic          i_restart,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic [15:0]   o_frame_cnt
);

  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_sync;
  logic          v_sync;
  logic          h_active;
  logic          v_active;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .advance (i_pix_en),
    .restart (i_restart),
    .count   (h_count),
    .wrap    (h_wrap),
    .sync    (h_sync),
    .active  (h_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .advance (h_wrap),
    .restart (i_restart),
    .count   (v_count),
    .wrap    (v_wrap),
    .sync    (v_sync),
    .active  (v_active)
  );

  // Single output stage: everything captured together so all outputs stay aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync       <= ~H_SYNC_POL;
      o_vsync       <= ~V_SYNC_POL;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      if (i_pix_en) begin
        o_hsync       <= h_sync;
        o_vsync       <= v_sync;
        o_de          <= h_active && v_active;
        o_x           <= h_count;
        o_y           <= v_count;
        o_line_start  <= (h_count == '0);
        o_frame_start <= (h_count == '0) && (v_count == '0);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  // Counts frame wraps in the same clock as the counter wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= 16'd0;
    end else if (i_restart) begin
      frame_cnt <= 16'd0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt;
`else
  logic unused_v_wrap;

  assign unused_v_wrap = v_wrap;
  assign o_frame_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a small raster (H 4/1/2/1, V 3/1/1/1,
// active-high syncs): H_TOT = 8, V_TOT = 6, 48 enables per frame.
module tb_vga_timing_gen;

  localparam int unsigned CW = 12;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } out_t;

  logic          clk;
  logic          i_rst_n;
  logic          i_pix_en;
  logic          i_restart;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_line_start;
  logic          o_frame_start;
  logic [15:0]   o_frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE   (4),
    .H_FP       (1),
    .H_SYNC     (2),
    .H_BP       (1),
    .V_ACTIVE   (3),
    .V_FP       (1),
    .V_SYNC     (1),
    .V_BP       (1),
    .H_SYNC_POL (1'b1),
    .V_SYNC_POL (1'b1),
    .CW         (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_pix_en      (i_pix_en),
    .i_restart     (i_restart),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_de          (o_de),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_line_start  (o_line_start),
    .o_frame_start (o_frame_start),
    .o_frame_cnt   (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  // Reference raster state: next position to be captured, frame count, outputs.
  int    mh  = 0;
  int    mv  = 0;
  int    mfc = 0;
  out_t  mo;
  out_t  rst_val;

  function automatic out_t dut_out();
    out_t r;
    r.hs = o_hsync;
    r.vs = o_vsync;
    r.de = o_de;
    r.x  = o_x;
    r.y  = o_y;
    r.ls = o_line_start;
    r.fs = o_frame_start;
    r.fc = o_frame_cnt;
    return r;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d want hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d",
               name, $time, act.hs, act.vs, act.de, act.x, act.y, act.ls, act.fs, act.fc,
               exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs, exp.fc);
    end
  endtask

  // Expected effect of one clock edge, hand-decoded for the small raster.
  task automatic model_edge(input bit pe, input bit rs, input bit rn);
    if (!rn) begin
      mh  = 0;
      mv  = 0;
      mfc = 0;
      mo  = rst_val;
      return;
    end
    mo.ls = 1'b0;
    mo.fs = 1'b0;
    if (pe) begin
      mo.hs = (mh == 5) || (mh == 6);
      mo.vs = (mv == 4);
      mo.de = (mh < 4) && (mv < 3);
      mo.x  = 12'(mh);
      mo.y  = 12'(mv);
      mo.ls = (mh == 0);
      mo.fs = (mh == 0) && (mv == 0);
    end
    if (rs) begin
      mh  = 0;
      mv  = 0;
      mfc = 0;
    end else if (pe) begin
      if (mh == 7) begin
        mh = 0;
        if (mv == 5) begin
          mv  = 0;
          mfc = (mfc + 1) % 65536;
        end else begin
          mv = mv + 1;
        end
      end else begin
        mh = mh + 1;
      end
    end
    mo.fc = FC_EN ? 16'(mfc) : 16'd0;
  endtask

  task automatic step(input bit pe, input bit rs, input bit rn);
    @(negedge clk);
    i_pix_en  = pe;
    i_restart = rs;
    i_rst_n   = rn;
    model_edge(pe, rs, rn);
    exp_q.push_back(mo);
  endtask

  // Monitor: compare the DUT against the queued expectation after every edge.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(phase, dut_out(), e);
      end
    end
  end

  initial begin
    int          guard;
    logic [15:0] pat;

    rst_val    = '0;
    rst_val.hs = 1'b0;
    rst_val.vs = 1'b0;
    mo         = rst_val;
    pat        = 16'b1011_0010_1110_0101;
    i_rst_n    = 1'b0;
    i_pix_en   = 1'b0;
    i_restart  = 1'b0;

    phase = "reset";
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // First enable captures (0,0) with both strobes; two frames at half rate.
    phase = "two_frames_half_rate";
    for (int i = 0; i < 192; i++) step(i % 2 == 0, 1'b0, 1'b1);

    phase = "seek_restart";
    guard = 0;
    while (!(mh == 5 && mv == 1) && guard < 200) begin
      step(1'b1, 1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL seek_restart timeout got guard=%0d want <200", guard);
    end

    phase = "restart_with_enable";
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(i % 2 == 1, 1'b0, 1'b1);

    phase = "restart_no_enable_hold";
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Three full frames after restart at full rate; frame count reaches 3.
    phase = "restart_three_frames";
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 147; i++) step(1'b1, 1'b0, 1'b1);

    phase = "irregular_enable";
    for (int i = 0; i < 64; i++) step(pat[i % 16], 1'b0, 1'b1);

    phase = "seek_hsync";
    guard = 0;
    while (mo.x != 12'd5 && guard < 20) begin
      step(1'b1, 1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (guard >= 20 || mo.hs !== 1'b1) begin
      errors++;
      $display("FAIL seek_hsync got guard=%0d hs=%0b want <20 and 1", guard, mo.hs);
    end

    // Reset between edges must take effect without a clock edge.
    phase = "async_reset";
    step(1'b0, 1'b0, 1'b0);
    #1;
    check("async_reset_immediate", dut_out(), rst_val);
    step(1'b0, 1'b0, 1'b0);

    phase = "post_reset";
    for (int i = 0; i < 20; i++) step(i % 2 == 0, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d entries want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
